// File: rtl/sr_ext_pkg.sv
// Shared definitions for the extension-unit sequencer/arbiter.
//   - FSM state encodings and the state enum built from them
//   - requester index constants (core path and debug port)
//   - helper that turns an owner index into a one-hot requester vector
package sr_ext_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_START = 2'd1;
    localparam logic [1:0] ENC_WAIT  = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ENC_IDLE,
        S_START = ENC_START,
        S_WAIT  = ENC_WAIT,
        S_DONE  = ENC_DONE
    } state_e;

    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_DBG  = 1;

    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sr_rr_arbiter2.sv
// Combinational 2-way round-robin pick.
//   req_i        : per-requester request vector
//   last_owner_i : index of the requester served most recently
//   gnt_o        : one-hot pick (all zero when nothing is requested)
// On a tie the requester that was NOT served last wins.
module sr_rr_arbiter2
    import sr_ext_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = owner_onehot(~last_owner_i);
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sr_ext_arbiter.sv
// Sequencer + 2-way round-robin arbiter sharing one multicycle functional
// unit (start/busy/result) between the core extension path (requester 0)
// and a debug/test port (requester 1).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i               : level requests, sampled only while idle
//   a0_i/b0_i, a1_i/b1_i: operands, held by a requester until its grant
//   gnt_o               : one-cycle one-hot pulse, operands captured
//   done_o              : one-cycle one-hot pulse, result on y_o
//   err_o               : with done_o when the watchdog aborted the operation
//   y_o                 : last result (zero after an abort), held
//   busy_o              : sequencer not idle
//   fu_start_o          : one-cycle start to the unit
//   fu_a_o/fu_b_o       : latched operands to the unit
//   fu_busy_i, fu_y_i   : unit status and result
// Handshake: a requester raises req_i with operands stable; the operands
// are taken in the gnt_o cycle, after which req_i may drop. The unit is
// started with fu_start_o and is considered finished when fu_busy_i is low
// after the first wait cycle.
module sr_ext_arbiter
    import sr_ext_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int Y_W     = 5,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [1:0]     req_i,
    input  logic [A_W-1:0] a0_i,
    input  logic [A_W-1:0] b0_i,
    input  logic [A_W-1:0] a1_i,
    input  logic [A_W-1:0] b1_i,
    output logic [1:0]     gnt_o,
    output logic [1:0]     done_o,
    output logic           err_o,
    output logic [Y_W-1:0] y_o,
    output logic           busy_o,
    output logic           fu_start_o,
    output logic [A_W-1:0] fu_a_o,
    output logic [A_W-1:0] fu_b_o,
    input  logic           fu_busy_i,
    input  logic [Y_W-1:0] fu_y_i
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic            owner_q;
    logic            last_owner_q;
    logic [WD_W-1:0] wd_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            err_q;
    logic [Y_W-1:0]  y_q;
    logic            start_q;
    logic [A_W-1:0]  a_q;
    logic [A_W-1:0]  b_q;

    logic [1:0]      pick;

    sr_rr_arbiter2 u_rr (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .gnt_o        (pick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wd_q         <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            y_q          <= '0;
            start_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A unit still running from before a reset blocks new work.
                    if (req_i != 2'b00 && !fu_busy_i) begin
                        owner_q <= pick[REQ_DBG];
                        a_q     <= pick[REQ_DBG] ? a1_i : a0_i;
                        b_q     <= pick[REQ_DBG] ? b1_i : b0_i;
                        gnt_q   <= pick;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // wd_q == 0 marks the first wait cycle, where fu_busy_i
                    // has only just been raised and cannot be trusted yet.
                    if (wd_q != '0 && !fu_busy_i) begin
                        y_q     <= fu_y_i;
                        done_q  <= owner_onehot(owner_q);
                        state_q <= S_DONE;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        y_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= owner_onehot(owner_q);
                        state_q <= S_DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_DONE: begin
                    last_owner_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign y_o        = y_q;
    assign busy_o     = (state_q != S_IDLE);
    assign fu_start_o = start_q;
    assign fu_a_o     = a_q;
    assign fu_b_o     = b_q;

endmodule

// File: tb/tb_sr_ext_arbiter.sv
module tb_sr_ext_arbiter;
  localparam int A_W = 8;
  localparam int Y_W = 5;
  localparam int TIMEOUT = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]     req = '0;
  logic [A_W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]     gnt_o, done_o;
  logic           err_o, busy_o, fu_start_o;
  logic [Y_W-1:0] y_o;
  logic [A_W-1:0] fu_a_o, fu_b_o;

  // functional unit model: busy for k_cfg cycles after a sampled start,
  // hang forces busy high; counter is not touched by the DUT reset
  int             k_cfg = 0;
  logic           hang = 1'b0;
  int             busy_cnt = 0;
  logic [Y_W-1:0] fu_y_val = '0;
  logic           fu_busy;

  always @(posedge clk) begin
    if (fu_start_o && k_cfg != 0) busy_cnt <= k_cfg;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign fu_busy = hang || (busy_cnt != 0);

  sr_ext_arbiter #(.A_W(A_W), .Y_W(Y_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .y_o(y_o),
    .busy_o(busy_o), .fu_start_o(fu_start_o),
    .fu_a_o(fu_a_o), .fu_b_o(fu_b_o),
    .fu_busy_i(fu_busy), .fu_y_i(fu_y_val)
  );

  // scoreboard
  logic [Y_W-1:0] exp_q[$];
  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks_no_done(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, done_o, 2'b00);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt_o == 2'b00 && n < 12) begin
      tick();
      n++;
    end
    chk(tag, (n < 12), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 20) begin
      tick();
      n++;
    end
    chk(tag, (n < 20), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_y"}, y_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_start"}, fu_start_o, 0);
    chk({tag, "_fua"}, fu_a_o, 0);
    chk({tag, "_fub"}, fu_b_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    // ---- reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // ---- single request, K=4 (cycle t = now)
    k_cfg = 4; fu_y_val = 5'd6; a0 = 8'd27; b0 = 8'd9; req = 2'b01;
    exp_q.push_back(5'd6);
    tick();                                  // t+1
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_start", fu_start_o, 1);
    chk("t1_fua", fu_a_o, 8'd27);
    chk("t1_fub", fu_b_o, 8'd9);
    chk("t1_busy", busy_o, 1);
    req = 2'b00; a0 = 8'd0; b0 = 8'd0;
    tick();                                  // t+2
    chk("t1_gnt_pulse", gnt_o, 2'b00);
    chk("t1_start_pulse", fu_start_o, 0);
    chk("t1_fua_hold", fu_a_o, 8'd27);
    ticks_no_done(4, "t1_early_done");      // t+3..t+6
    tick();                                  // t+7
    chk("t1_done", done_o, 2'b01);
    chk("t1_y", y_o, exp_q.pop_front());
    chk("t1_err", err_o, 0);
    tick();                                  // t+8
    chk("t1_done_pulse", done_o, 2'b00);
    chk("t1_y_hold", y_o, 5'd6);
    chk("t1_idle", busy_o, 0);

    // ---- simultaneous requests after reset, K=2
    rst = 1'b1; tick(); rst = 1'b0;
    k_cfg = 2; fu_y_val = 5'd9;
    a0 = 8'd1; b0 = 8'd2; a1 = 8'd3; b1 = 8'd4; req = 2'b11;
    exp_q.push_back(5'd9);
    exp_q.push_back(5'd12);
    tick();                                  // t+1
    chk("t2_gnt0", gnt_o, 2'b01);
    chk("t2_fua0", fu_a_o, 8'd1);
    chk("t2_fub0", fu_b_o, 8'd2);
    req = 2'b10;
    ticks_no_done(3, "t2_early_done0");     // t+2..t+4
    tick();                                  // t+5
    chk("t2_done0", done_o, 2'b01);
    chk("t2_y0", y_o, exp_q.pop_front());
    fu_y_val = 5'd12;
    tick();                                  // t+6
    chk("t2_no_overlap", gnt_o, 2'b00);
    tick();                                  // t+7
    chk("t2_gnt1", gnt_o, 2'b10);
    chk("t2_fua1", fu_a_o, 8'd3);
    chk("t2_fub1", fu_b_o, 8'd4);
    req = 2'b00;
    ticks_no_done(3, "t2_early_done1");     // t+8..t+10
    tick();                                  // t+11
    chk("t2_done1", done_o, 2'b10);
    chk("t2_y1", y_o, exp_q.pop_front());

    // ---- both held: grants alternate 0,1,0,1
    k_cfg = 0; fu_y_val = 5'd17;
    a0 = 8'd10; b0 = 8'd11; a1 = 8'd20; b1 = 8'd21; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("t3_gnt_bound");
      chk("t3_alt_gnt", gnt_o, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("t3_alt_fua", fu_a_o, (i % 2 == 1) ? 8'd20 : 8'd10);
      tick();
    end
    req = 2'b00;
    wait_idle("t3_idle_bound");
    chk("t3_y", y_o, 5'd17);

    // ---- watchdog abort: unit never drops busy
    k_cfg = 0; req = 2'b10;
    tick();                                  // t+1
    chk("t4_gnt", gnt_o, 2'b10);
    req = 2'b00; hang = 1'b1;
    ticks_no_done(9, "t4_early_done");      // t+2..t+10
    chk("t4_busy", busy_o, 1);
    tick();                                  // t+11
    chk("t4_done", done_o, 2'b10);
    chk("t4_err", err_o, 1);
    chk("t4_y", y_o, 0);
    hang = 1'b0;
    tick();                                  // t+12
    chk("t4_idle", busy_o, 0);
    chk("t4_err_pulse", err_o, 0);

    // ---- reset during WAIT while the unit keeps running
    k_cfg = 6; fu_y_val = 5'd21; a1 = 8'd44; b1 = 8'd55; req = 2'b10;
    tick();                                  // t+1
    chk("t5_gnt", gnt_o, 2'b10);
    tick(); tick(); tick();                  // t+2..t+4
    rst = 1'b1;
    tick();                                  // t+5
    chk_all_zero("t5_rst");
    rst = 1'b0; k_cfg = 1;
    exp_q.push_back(5'd21);
    for (int i = 0; i < 3; i++) begin        // t+6..t+8
      tick();
      chk("t5_withheld_gnt", gnt_o, 2'b00);
      chk("t5_no_done", done_o, 2'b00);
    end
    tick();                                  // t+9
    chk("t5_gnt_after", gnt_o, 2'b10);
    chk("t5_fua", fu_a_o, 8'd44);
    req = 2'b00;
    ticks_no_done(2, "t5_early_done");      // t+10..t+11
    tick();                                  // t+12
    chk("t5_done", done_o, 2'b10);
    chk("t5_y", y_o, exp_q.pop_front());
    chk("t5_err", err_o, 0);

    // ---- K=0 and a stray request pulse during WAIT
    tick();                                  // back in IDLE
    k_cfg = 0; fu_y_val = 5'd3; a0 = 8'd7; b0 = 8'd8; req = 2'b01;
    exp_q.push_back(5'd3);
    tick();                                  // t+1
    chk("t6_gnt", gnt_o, 2'b01);
    req = 2'b00;
    tick();                                  // t+2
    req = 2'b10;
    tick();                                  // t+3
    req = 2'b00;
    chk("t6_no_done_t3", done_o, 2'b00);
    tick();                                  // t+4
    chk("t6_done", done_o, 2'b01);
    chk("t6_y", y_o, exp_q.pop_front());
    tick();                                  // t+5
    chk("t6_no_gnt_t5", gnt_o, 2'b00);
    tick();                                  // t+6
    chk("t6_no_gnt_t6", gnt_o, 2'b00);
    chk("t6_idle", busy_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sr_ext_arbiter.md
# sr_ext_arbiter

Sequencer and 2-way round-robin arbiter that shares one multicycle functional unit (cbrt_sum_sqrt-style: start/busy/result) between two requesters, typically the CPU core's extension-instruction path (requester 0) and a debug/test port (requester 1). It captures operands, issues a one-cycle start, waits out the unit's busy phase under a watchdog, returns the result to the owning requester and rotates priority. It sits between the core's control/ALU stall logic and the functional unit.

## Interface
Parameters:
- A_W, 8, operand width per input
- Y_W, 5, result width
- TIMEOUT, 255, max WAIT cycles before abort (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- req_i  in  2  per-requester operation request (level)
- a0_i, b0_i  in  A_W each  requester 0 operands
- a1_i, b1_i  in  A_W each  requester 1 operands
- gnt_o  out  2  one-hot, one-cycle pulse: operands captured for that requester
- done_o  out  2  one-hot, one-cycle pulse: result ready on y_o
- err_o  out  1  one-cycle pulse coincident with done_o on watchdog abort
- y_o  out  Y_W  last result, held until next done_o
- busy_o  out  1  high in every state except IDLE
- fu_start_o  out  1  one-cycle start to functional unit
- fu_a_o, fu_b_o  out  A_W each  latched operands, stable from START through DONE
- fu_busy_i  in  1  unit busy; contract: rises the cycle after fu_start_o is sampled
- fu_y_i  in  Y_W  unit result, valid when fu_busy_i low after operation

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: if req_i≠0 and fu_busy_i=0 → pick owner, latch operands, go START. If fu_busy_i=1 (unit still running after our reset), stay IDLE.
- Owner pick: single request → that one; both → requester ≠ last_owner. last_owner resets to 1 (requester 0 wins first tie).
- START: fu_start_o=1, gnt_o[owner]=1; → WAIT; watchdog cleared.
- WAIT: first cycle always waits; thereafter fu_busy_i=0 → latch fu_y_i into y_o, → DONE. Watchdog increments each WAIT cycle; reaching TIMEOUT → y_o=0, set abort flag, → DONE.
- DONE: done_o[owner]=1, err_o=abort flag, last_owner←owner; → IDLE.
- req_i sampled only in IDLE; withdrawal before grant is legal and ignored. Requester holds operands until gnt_o; may drop req_i any time after.
- Reset (any state): state IDLE, all outputs 0 (gnt_o, done_o, err_o, y_o, busy_o, fu_start_o, fu_a_o, fu_b_o), last_owner=1, watchdog=0. No done_o issued for an aborted-by-reset operation.

## Timing
- Request seen in IDLE cycle t → gnt_o and fu_start_o at t+1 → WAIT from t+2.
- Unit busy for K cycles (t+2..t+1+K) → y_o latched edge ending t+2+K → done_o at t+3+K; y_o valid from t+3+K.
- K=0 (busy never raised): done_o at t+4 (first WAIT cycle is mandatory).
- Back-to-back: next IDLE at t+4+K; earliest next grant t+5+K.
- Timeout: err_o/done_o at t+3+TIMEOUT.
- Max one operation outstanding; throughput ≤ 1 per K+4 cycles.

## Structure
- Package sr_ext_pkg: state encoding localparams (IDLE/START/WAIT/DONE), requester index constants REQ_CORE=0, REQ_DBG=1.
- Sub-module sr_rr_arbiter2: combinational 2-way round-robin pick from req and last_owner, output one-hot grant; FSM and datapath latches stay in sr_ext_arbiter.

## Test plan
- Reset then req_i=01, a0=8'd27, b0=8'd9, model unit K=4, fu_y=5'd6 → gnt_o=01 at t+1, fu_a_o=27/fu_b_o=9 from t+1, done_o=01 and y_o=6 at t+7.
- req_i=11 after reset, K=2 → requester 0 granted first, done_o=01; requester 1 granted next IDLE, done_o=10; both in flight never overlap.
- Requester 0 holds req continuously, requester 1 asserts req → grants alternate 0,1,0,1.
- Unit never drops busy, TIMEOUT=8 → done_o[owner] and err_o together at t+11, y_o=0, FSM returns IDLE.
- rst_i in WAIT with model busy held 3 more cycles, req_i=10 → no done_o, all outputs 0, gnt_o withheld until fu_busy_i low, then normal completion.
- K=0 model → done_o exactly at t+4; req_i pulsed one cycle while in WAIT → ignored, no extra grant.
